// File: rtl/mc_control_fsm.sv
// ============================================================================
// Module      : mc_control_fsm
// Description : Multi-cycle MIPS main control sequencer with memory-ready
//               stalls, illegal-opcode pulse and retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC     = 4'd6,
        ALU_WB   = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        retire        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;

        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                // IR and PC load only on the cycle the fetch actually completes
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d    = FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) state_d = MEM_WB;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = FETCH;
                retire     = 1'b1;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    state_d = FETCH;
                    retire  = 1'b1;
                end
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = ALU_WB;
            end
            ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = FETCH;
                retire    = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                state_d       = FETCH;
                retire        = 1'b1;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                state_d   = FETCH;
                retire    = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    assign retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    assign retired   = retired_q;
    assign state     = state_q;

endmodule

`default_nettype wire

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multi-cycle MIPS main control sequencer. It steps each instruction through fetch, decode, execute, memory and writeback states, and drives the shared ALU, memory port, instruction register, register file and PC write enables for one cycle per state. It sits between the instruction register opcode field and the single-ported unified memory/datapath, and stalls on a memory ready handshake. A retired-instruction counter and an illegal-opcode flag are provided for debug.

## Interface
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26]; valid from DECODE onward
- mem_ready  in  1  memory completes current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero (BEQ)
- i_or_d  out  1  memory address source: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  load instruction register
- mem_to_reg  out  1  regfile write data: 0=ALUOut, 1=MDR
- reg_write  out  1  regfile write enable
- reg_dst  out  1  dest reg: 0=rt, 1=rd
- alu_src_a  out  1  0=PC, 1=reg A
- alu_src_b  out  2  00=reg B, 01=const 4, 10=sext imm, 11=sext imm<<2
- alu_op  out  2  00=add, 01=sub, 10=funct-decoded
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
- state  out  4  current state encoding (debug)
- illegal_op  out  1  one-cycle pulse on unsupported opcode
- retired  out  CNT_W  count of completed instructions, wraps

## Operation
- States/encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC=6, ALU_WB=7, BRANCH=8, JUMP=9. Encodings 10-15 unreachable; if entered, next state FETCH.
- All outputs not listed for a state are 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready. Stay until mem_ready, then DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target to ALUOut). Next: LW(100011)/SW(101011) -> MEM_ADDR; R-type(000000) -> EXEC; BEQ(000100) -> BRANCH; J(000010) -> JUMP; other -> FETCH with illegal_op=1 this cycle.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next MEM_RD if LW, MEM_WR if SW.
- MEM_RD: mem_read=1, i_or_d=1; stay until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; next FETCH.
- MEM_WR: mem_write=1, i_or_d=1; stay until mem_ready, then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; next ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0, reg_dst=1; next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; next FETCH.
- JUMP: pc_write=1, pc_source=10; next FETCH.
- retired increments by 1 on every transition into FETCH from MEM_WB, MEM_WR (with mem_ready), ALU_WB, BRANCH or JUMP; not on illegal opcode; wraps modulo 2^CNT_W.
- Opcode is sampled only in DECODE and MEM_ADDR; changes elsewhere are ignored.

## Timing
- Reset (rst_n=0, async): state=FETCH, retired=0, illegal_op=0. All other outputs are combinational from state and mem_ready, so during reset FETCH values are driven (mem_read=1, alu_src_b=01, i_or_d=0).
- Reset mid-instruction aborts it; no writes occur after rst_n falls; first FETCH begins on the first clk edge after rst_n rises.
- Outputs are Moore, from the state register, except ir_write/pc_write in FETCH, which are gated by mem_ready. Illegal_op is combinational in DECODE.
- With zero-wait memory (mem_ready=1 always), cycles: R-type 4, LW 5, SW 4, BEQ 3, J 3, illegal 2.
- Each wait cycle (mem_ready=0) in FETCH/MEM_RD/MEM_WR adds one cycle with outputs held; mem_ready outside those states is ignored.

## Test plan
- Reset: assert rst_n=0 mid-EXEC -> state=0, retired=0 immediately; after release, FETCH with mem_read=1, ir_write=1 when mem_ready=1.
- R-type, mem_ready=1: opcode=000000 -> states 0,1,6,7,0; reg_write=1 and reg_dst=1 only in state 7; retired 0->1.
- LW with 2 wait cycles in MEM_RD: opcode=100011 -> 0,1,2,3,3,3,4,0; mem_read and i_or_d=1 held for 3 cycles; retired +1.
- SW then BEQ then J back-to-back -> 4, 3 and 3 cycles; mem_write=1 only in MEM_WR; pc_write_cond=1 with alu_op=01 in BRANCH; pc_source=10 in JUMP; retired=3.
- Illegal opcode 111111 -> illegal_op=1 for one cycle in DECODE, then FETCH, no reg_write/mem_write, retired unchanged.
- Wrap: CNT_W=4, 16 R-type instructions -> retired returns to 0.
